// File: rtl/rega_display_timer.sv
// Irrigation countdown timer (sprinkler/drip) with fault pause and a
// multiplexed common-anode 7-segment display driver.
module rega_display_timer #(
    parameter int N_DIG    = 4,
    parameter int T_ASP    = 30,
    parameter int T_GOT    = 15,
    parameter int SCAN_DIV = 1000
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Tick,
    input  logic             Bs,
    input  logic             Vs,
    input  logic             ERRO,
    input  logic             Ve,
    output logic             Valve_out,
    output logic             Done,
    output logic [6:0]       SEGs,
    output logic [N_DIG-1:0] SEG_D,
    output logic             SEG_P
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

    localparam logic [3:0] ASP_TENS  = 4'(T_ASP / 10);
    localparam logic [3:0] ASP_UNITS = 4'(T_ASP % 10);
    localparam logic [3:0] GOT_TENS  = 4'(T_GOT / 10);
    localparam logic [3:0] GOT_UNITS = 4'(T_GOT % 10);

    localparam logic [6:0] G_A     = 7'h08;
    localparam logic [6:0] G_G     = 7'h42;
    localparam logic [6:0] G_D     = 7'h21;
    localparam logic [6:0] G_E     = 7'h06;
    localparam logic [6:0] G_R     = 7'h2F;
    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        IDLE,
        RUN_ASP,
        RUN_GOT,
        PAUSE,
        DONE
    } state_t;

    state_t     state, stateNext;
    logic [3:0] tens, units, tensNext, unitsNext;
    logic       mode, modeNext;
    logic       doneNext;
    logic       req;
    logic       running;

    logic [CW-1:0] scanCnt;
    logic [IW-1:0] scanIdx;
    logic [31:0]   idxVal;
    logic [6:0]    segNext;
    logic          pNext;

    function automatic logic [6:0] digitGlyph(input logic [3:0] d);
        case (d)
            4'd0:    digitGlyph = 7'h40;
            4'd1:    digitGlyph = 7'h79;
            4'd2:    digitGlyph = 7'h24;
            4'd3:    digitGlyph = 7'h30;
            4'd4:    digitGlyph = 7'h19;
            4'd5:    digitGlyph = 7'h12;
            4'd6:    digitGlyph = 7'h02;
            4'd7:    digitGlyph = 7'h78;
            4'd8:    digitGlyph = 7'h00;
            4'd9:    digitGlyph = 7'h10;
            default: digitGlyph = G_BLANK;
        endcase
    endfunction

    // mode selects which request keeps a RUN/PAUSE alive: 0 = sprinkler, 1 = drip
    assign req     = mode ? Vs : Bs;
    assign running = (state == RUN_ASP) || (state == RUN_GOT);

    always_comb begin
        stateNext = state;
        tensNext  = tens;
        unitsNext = units;
        modeNext  = mode;
        doneNext  = 1'b0;
        case (state)
            IDLE: begin
                if (!ERRO) begin
                    if (Bs) begin
                        stateNext = RUN_ASP;
                        tensNext  = ASP_TENS;
                        unitsNext = ASP_UNITS;
                        modeNext  = 1'b0;
                    end else if (Vs) begin
                        stateNext = RUN_GOT;
                        tensNext  = GOT_TENS;
                        unitsNext = GOT_UNITS;
                        modeNext  = 1'b1;
                    end
                end
            end
            RUN_ASP, RUN_GOT: begin
                if (!req) begin
                    stateNext = IDLE;
                    tensNext  = '0;
                    unitsNext = '0;
                end else if (ERRO) begin
                    stateNext = PAUSE;
                end else if (Tick) begin
                    if (tens == 4'd0 && units == 4'd1) begin
                        stateNext = DONE;
                        unitsNext = '0;
                        doneNext  = 1'b1;
                    end else if (units == 4'd0) begin
                        unitsNext = 4'd9;
                        tensNext  = tens - 4'd1;
                    end else begin
                        unitsNext = units - 4'd1;
                    end
                end
            end
            PAUSE: begin
                if (!req) begin
                    stateNext = IDLE;
                    tensNext  = '0;
                    unitsNext = '0;
                end else if (!ERRO) begin
                    stateNext = mode ? RUN_GOT : RUN_ASP;
                end
            end
            DONE: begin
                if (!Bs && !Vs) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            tens      <= '0;
            units     <= '0;
            mode      <= 1'b0;
            Done      <= 1'b0;
            Valve_out <= 1'b0;
        end else begin
            state     <= stateNext;
            tens      <= tensNext;
            units     <= unitsNext;
            mode      <= modeNext;
            Done      <= doneNext;
            Valve_out <= (stateNext == RUN_ASP) || (stateNext == RUN_GOT);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            scanCnt <= '0;
            scanIdx <= '0;
        end else if (scanCnt == SCAN_LAST) begin
            scanCnt <= '0;
            scanIdx <= (scanIdx == IDX_LAST) ? '0 : scanIdx + 1'b1;
        end else begin
            scanCnt <= scanCnt + 1'b1;
        end
    end

    assign idxVal = 32'(scanIdx);

    always_comb begin
        segNext = G_BLANK;
        pNext   = 1'b1;
        if (ERRO) begin
            case (idxVal)
                32'd0, 32'd1: segNext = G_R;
                32'd2:        segNext = G_E;
                default:      segNext = G_BLANK;
            endcase
        end else begin
            case (idxVal)
                32'd0: segNext = digitGlyph(units);
                32'd1: begin
                    // leading zero suppressed while a countdown is shown
                    segNext = (tens == 4'd0 && state != IDLE) ? G_BLANK : digitGlyph(tens);
                    pNext   = !running;
                end
                32'd2: begin
                    case (state)
                        RUN_ASP: segNext = G_A;
                        RUN_GOT: segNext = G_G;
                        DONE:    segNext = G_D;
                        default: segNext = G_DASH;
                    endcase
                end
                32'd3:   segNext = Ve ? digitGlyph(4'd1) : digitGlyph(4'd0);
                default: segNext = G_BLANK;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            SEGs  <= G_BLANK;
            SEG_D <= '1;
            SEG_P <= 1'b1;
        end else begin
            SEGs  <= segNext;
            SEG_D <= ~(N_DIG'(1) << scanIdx);
            SEG_P <= pNext;
        end
    end

endmodule
